flit_activity_monitor: RTL and testbench



---
 rtl/flit_activity_monitor_pkg.sv | 25 ++
 rtl/flit_activity_monitor_if.sv | 32 +++
 rtl/flit_activity_monitor_popcount.sv | 17 +
 rtl/flit_activity_monitor.sv | 141 ++++++++++++++
 tb/tb_flit_activity_monitor.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flit_activity_monitor_pkg.sv
// flit_mon_pkg: default widths, FSM state encoding and the saturating-add
// helper shared by flit_activity_monitor and its interface.
package flit_mon_pkg;

  localparam int unsigned DEF_N     = 25;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_TOG_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Adds two values and clamps the result to the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[63:0];
  endfunction

endpackage

// File: rtl/flit_activity_monitor_if.sv
// flit_activity_monitor_if: flit input stream and the per-packet report
// record handshake. master = traffic source / record consumer, slave = monitor.
interface flit_activity_monitor_if
  import flit_mon_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TOG_W = DEF_TOG_W
);
  localparam int unsigned PW = $clog2(N + 1);

  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_flits;
  logic [TOG_W-1:0] rpt_toggles;
  logic [CNT_W-1:0] rpt_gap;
  logic [PW-1:0]    rpt_peak;
  logic             overflow;

  modport master (
    output in_valid, in_data, rpt_ready,
    input  rpt_valid, rpt_flits, rpt_toggles, rpt_gap, rpt_peak, overflow
  );

  modport slave (
    input  in_valid, in_data, rpt_ready,
    output rpt_valid, rpt_flits, rpt_toggles, rpt_gap, rpt_peak, overflow
  );

endinterface

// File: rtl/flit_activity_monitor_popcount.sv
// popcount: purely combinational count of set bits in a W-bit vector.
module popcount #(
  parameter int unsigned W = 25
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int unsigned CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/flit_activity_monitor.sv
// flit_activity_monitor: delimits packets on a flit bus, accumulates flit count,
// toggle activity and preceding idle gap, and reports one record per packet.
// Optional per-packet peak-toggle tracking is built when FLIT_MON_PEAK_EN is defined.
module flit_activity_monitor
  import flit_mon_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TOG_W = DEF_TOG_W
) (
  input logic                     clk,
  input logic                     rst,
  flit_activity_monitor_if.slave  bus
);
  localparam int unsigned PW = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [N-1:0]     prev_data;
  logic [N-1:0]     diff;
  logic [PW-1:0]    ham;
  logic [CNT_W-1:0] flit_q, flit_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] pkt_gap_q, pkt_gap_d;
  logic             commit;
  logic             load;

  assign diff = bus.in_data ^ prev_data;

  popcount #(.W(N)) u_popcount (
    .vec (diff),
    .cnt (ham)
  );

  always_comb begin
    state_d   = state_q;
    flit_d    = flit_q;
    tog_d     = tog_q;
    gap_d     = gap_q;
    pkt_gap_d = pkt_gap_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = PKT;
          flit_d    = CNT_W'(1);
          tog_d     = TOG_W'(ham);
          pkt_gap_d = gap_q;
          gap_d     = '0;
        end else begin
          gap_d = CNT_W'(sat_add(64'(gap_q), 64'd1, CNT_W));
        end
      end
      PKT: begin
        if (bus.in_valid) begin
          flit_d = CNT_W'(sat_add(64'(flit_q), 64'd1, CNT_W));
          tog_d  = TOG_W'(sat_add(64'(tog_q), 64'(ham), TOG_W));
        end else begin
          // The packet-end cycle is itself idle, so the next gap starts at 1.
          state_d = IDLE;
          commit  = 1'b1;
          gap_d   = CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_data <= '0;
      flit_q    <= '0;
      tog_q     <= '0;
      gap_q     <= '0;
      pkt_gap_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_data <= bus.in_data;
      flit_q    <= flit_d;
      tog_q     <= tog_d;
      gap_q     <= gap_d;
      pkt_gap_q <= pkt_gap_d;
    end
  end

  // A commit may land in the same cycle the held record is accepted.
  assign load = commit && (!bus.rpt_valid || bus.rpt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rpt_valid   <= 1'b0;
      bus.rpt_flits   <= '0;
      bus.rpt_toggles <= '0;
      bus.rpt_gap     <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      if (load) begin
        bus.rpt_valid   <= 1'b1;
        bus.rpt_flits   <= flit_q;
        bus.rpt_toggles <= tog_q;
        bus.rpt_gap     <= pkt_gap_q;
      end else if (bus.rpt_valid && bus.rpt_ready) begin
        bus.rpt_valid <= 1'b0;
      end
      if (commit && !load) begin
        bus.overflow <= 1'b1;
      end
    end
  end

`ifdef FLIT_MON_PEAK_EN
  logic [PW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (bus.in_valid) begin
      if (state_q == IDLE) begin
        peak_d = ham;
      end else if (ham > peak_q) begin
        peak_d = ham;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q       <= '0;
      bus.rpt_peak <= '0;
    end else begin
      peak_q <= peak_d;
      if (load) begin
        bus.rpt_peak <= peak_q;
      end
    end
  end
`else
  assign bus.rpt_peak = '0;
`endif

endmodule

// File: tb/tb_flit_activity_monitor.sv
// tb_flit_activity_monitor: directed stimulus with a packet-level reference model
// and per-cycle output comparison; a CNT_W=4 instance covers counter saturation.
module tb_flit_activity_monitor;
  localparam int unsigned N   = 25;
  localparam int unsigned CW  = 16;
  localparam int unsigned TW  = 24;
  localparam int unsigned SCW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam int unsigned TMAX = (1 << TW) - 1;

  typedef struct {
    int unsigned flits;
    int unsigned toggles;
    int unsigned gap;
    int unsigned peak;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         rpt_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  flit_activity_monitor_if #(.N(N), .CNT_W(CW),  .TOG_W(TW)) bus ();
  flit_activity_monitor_if #(.N(N), .CNT_W(SCW), .TOG_W(TW)) sbus ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.rpt_ready  = rpt_ready;
  assign sbus.in_valid  = in_valid;
  assign sbus.in_data   = in_data;
  assign sbus.rpt_ready = rpt_ready;

  flit_activity_monitor #(.N(N), .CNT_W(CW), .TOG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flit_activity_monitor #(.N(N), .CNT_W(SCW), .TOG_W(TW)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned pk(input int unsigned p);
`ifdef FLIT_MON_PEAK_EN
    return p;
`else
    return (p == 0) ? 0 : 0;
`endif
  endfunction

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: packet = list of per-flit Hamming distances; gap = idle cycles since last flit.
  int unsigned  m_hams[$];
  bit           m_in_pkt;
  int unsigned  m_idle;
  int unsigned  m_start_gap;
  logic [N-1:0] m_prev;
  bit           m_bv;
  bit           m_ovf;
  rec_t         m_buf;

  always @(posedge clk) begin
    int unsigned ham;
    int unsigned sum;
    int unsigned mx;
    bit          commit;
    rec_t        r;
    if (rst) begin
      m_hams.delete();
      m_in_pkt = 0;
      m_idle   = 0;
      m_prev   = '0;
      m_bv     = 0;
      m_ovf    = 0;
    end else begin
      commit = 0;
      ham    = $countones(in_data ^ m_prev);
      if (in_valid) begin
        if (!m_in_pkt) begin
          m_start_gap = umin(m_idle, CMAX);
          m_hams.delete();
        end
        m_hams.push_back(ham);
        m_in_pkt = 1;
        m_idle   = 0;
      end else begin
        m_idle++;
        if (m_in_pkt) begin
          sum = 0;
          mx  = 0;
          foreach (m_hams[i]) begin
            sum += m_hams[i];
            if (m_hams[i] > mx) mx = m_hams[i];
          end
          r.flits   = umin(m_hams.size(), CMAX);
          r.toggles = umin(sum, TMAX);
          r.gap     = m_start_gap;
          r.peak    = pk(mx);
          m_in_pkt  = 0;
          commit    = 1;
        end
      end
      if (commit) begin
        if (m_bv && !rpt_ready) m_ovf = 1;
        else begin
          m_buf = r;
          m_bv  = 1;
        end
      end else if (m_bv && rpt_ready) begin
        m_bv = 0;
      end
      m_prev = in_data;
    end
  end

  // Records actually handed over by each DUT.
  rec_t dlog[$];
  rec_t slog[$];

  always @(posedge clk) begin
    if (!rst && bus.rpt_valid && rpt_ready)
      dlog.push_back('{int'(bus.rpt_flits), int'(bus.rpt_toggles), int'(bus.rpt_gap), int'(bus.rpt_peak)});
    if (!rst && sbus.rpt_valid && rpt_ready)
      slog.push_back('{int'(sbus.rpt_flits), int'(sbus.rpt_toggles), int'(sbus.rpt_gap), int'(sbus.rpt_peak)});
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rpt_valid", bus.rpt_valid, m_bv);
      chk("overflow", bus.overflow, m_ovf);
      if (m_bv) begin
        chk("rpt_flits", bus.rpt_flits, m_buf.flits);
        chk("rpt_toggles", bus.rpt_toggles, m_buf.toggles);
        chk("rpt_gap", bus.rpt_gap, m_buf.gap);
        chk("rpt_peak", bus.rpt_peak, m_buf.peak);
      end
    end
  end

  task automatic step(input logic v, input logic [N-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    rpt_ready = r;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic r);
    for (int unsigned i = 0; i < n; i++) step(1'b0, in_data, r);
  endtask

  task automatic do_reset(input int unsigned n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    rpt_ready = 1'b0;
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_rec(input string nm, input rec_t got, input int unsigned f,
                         input int unsigned t, input int unsigned g, input int unsigned p);
    chk({nm, ".flits"}, got.flits, f);
    chk({nm, ".toggles"}, got.toggles, t);
    chk({nm, ".gap"}, got.gap, g);
    chk({nm, ".peak"}, got.peak, pk(p));
  endtask

  initial begin
    int unsigned base;
    int unsigned sbase;
    rec_t        empty;
    empty = '{0, 0, 0, 0};

    @(negedge clk);
    // Basic packet and gap measurement
    do_reset(2);
    chk("reset.rpt_valid", bus.rpt_valid, 0);
    chk("reset.rpt_flits", bus.rpt_flits, 0);
    chk("reset.rpt_toggles", bus.rpt_toggles, 0);
    chk("reset.rpt_gap", bus.rpt_gap, 0);
    chk("reset.rpt_peak", bus.rpt_peak, 0);
    chk("reset.overflow", bus.overflow, 0);
    idle(3, 1'b1);
    for (int unsigned i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 25'h1FFFFFF : 25'h0, 1'b1);
    chk("latency.before", bus.rpt_valid, 0);
    step(1'b0, in_data, 1'b1);
    chk("latency.one", bus.rpt_valid, 1);
    idle(6, 1'b1);
    for (int unsigned i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 25'h3 : 25'h0, 1'b1);
    idle(4, 1'b1);
    chk("basic.count", dlog.size(), 2);
    chk_rec("basic", (dlog.size() > 0) ? dlog[0] : empty, 20, 500, 3, 25);
    chk_rec("gap", (dlog.size() > 1) ? dlog[1] : empty, 20, 40, 7, 2);

    // Backpressure: second record dropped while the first is held
    do_reset(1);
    base = dlog.size();
    idle(2, 1'b0);
    step(1'b1, 25'h1, 1'b0); step(1'b1, 25'h3, 1'b0); step(1'b1, 25'h7, 1'b0); step(1'b1, 25'hF, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 25'h0, 1'b0); step(1'b1, 25'hFF, 1'b0); step(1'b1, 25'h0, 1'b0); step(1'b1, 25'hFF, 1'b0);
    idle(1, 1'b0);
    chk("bp.overflow", bus.overflow, 1);
    idle(5, 1'b0);
    chk("bp.held_flits", bus.rpt_flits, 4);
    chk("bp.held_toggles", bus.rpt_toggles, 4);
    idle(4, 1'b1);
    chk("bp.count", dlog.size(), base + 1);
    chk_rec("bp", (dlog.size() > base) ? dlog[base] : empty, 4, 4, 2, 1);
    chk("bp.overflow_sticky", bus.overflow, 1);

    // Accept and commit in the same cycle
    do_reset(1);
    base = dlog.size();
    idle(1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 25'h10, 1'b0);
    idle(2, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 25'h1000000, 1'b0);
    step(1'b0, in_data, 1'b1);
    chk("collide.overflow", bus.overflow, 0);
    chk("collide.rpt_valid", bus.rpt_valid, 1);
    chk("collide.rpt_flits", bus.rpt_flits, 5);
    idle(3, 1'b1);
    chk("collide.count", dlog.size(), base + 2);
    chk_rec("collide.a", (dlog.size() > base) ? dlog[base] : empty, 3, 1, 1, 1);
    chk_rec("collide.c", (dlog.size() > base + 1) ? dlog[base + 1] : empty, 5, 2, 2, 2);

    // Saturation on the CNT_W=4 instance
    do_reset(1);
    base  = dlog.size();
    sbase = slog.size();
    idle(1, 1'b1);
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 25'h5, 1'b1);
    idle(3, 1'b1);
    chk("sat.count", slog.size(), sbase + 1);
    chk_rec("sat", (slog.size() > sbase) ? slog[sbase] : empty, 15, 2, 1, 2);
    chk_rec("sat.wide", (dlog.size() > base) ? dlog[base] : empty, 20, 2, 1, 2);

    // Reset in the middle of a packet
    do_reset(1);
    base = dlog.size();
    idle(2, 1'b1);
    for (int unsigned i = 0; i < 9; i++) step(1'b1, 25'hAA, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 25'hAA, 1'b1);
    idle(3, 1'b1);
    chk("rstmid.count", dlog.size(), base + 1);
    chk_rec("rstmid", (dlog.size() > base) ? dlog[base] : empty, 10, 4, 0, 4);
    chk("rstmid.overflow", bus.overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
